// File: rtl/mem_access_unit.sv
// Purpose: memory-stage load/store unit; drives one req/ready bus transaction per RV32 load/store.
// Latency: a legal access stalls for 1 + (WAIT cycles); a zero-wait bus gives 2 stall cycles, then DONE.
// Backpressure: stall_out freezes the pipeline while the bus withholds bus_ready, up to TIMEOUT_CYCLES.
// Ports: clk/rst (sync, active-high); EX/MEM request in (mem_read_in, mem_write_in, funct3_in,
//        addr_in, store_data_in); MEM/WB data out (mem_rdata_out); pipeline control (stall_out);
//        error pulses (access_err, bus_err); data-memory bus (bus_req/we/addr/wdata/wstrb, bus_ready/rdata).
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic [31:0] mem_rdata_out,
    output logic        stall_out,
    output logic        access_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aerr_q, aerr_d;
    logic        berr_q, berr_d;

    logic        access;
    logic        legal_code;
    logic        aligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    // A simultaneous read and write is treated as a read.
    assign access = mem_read_in | mem_write_in;

    always_comb begin
        legal_code = 1'b0;
        if (mem_read_in) begin
            legal_code = funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else begin
            legal_code = funct3_in inside {3'b000, 3'b001, 3'b010};
        end
    end

    // funct3[1:0] encodes the size for both signed and unsigned variants.
    always_comb begin
        aligned = 1'b1;
        case (funct3_in[1:0])
            2'b01:   aligned = ~addr_in[0];
            2'b10:   aligned = (addr_in[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    // Lane replication lets the bus pick the right byte lanes via wstrb alone.
    always_comb begin
        st_wdata = store_data_in;
        st_wstrb = 4'b1111;
        case (funct3_in[1:0])
            2'b00: begin
                st_wdata = {4{store_data_in[7:0]}};
                st_wstrb = 4'b0001 << addr_in[1:0];
            end
            2'b01: begin
                st_wdata = {2{store_data_in[15:0]}};
                st_wstrb = 4'b0011 << addr_in[1:0];
            end
            default: begin
                st_wdata = store_data_in;
                st_wstrb = 4'b1111;
            end
        endcase
        if (mem_read_in) begin
            st_wdata = '0;
            st_wstrb = 4'b0000;
        end
    end

    // Load alignment uses the size/offset latched at issue.
    assign ld_shift = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        off_d     = off_q;
        rdata_d   = rdata_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aerr_d    = 1'b0;
        berr_d    = 1'b0;
        stall_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (legal_code && aligned) begin
                        stall_out = 1'b1;
                        state_d   = S_WAIT;
                        req_d     = 1'b1;
                        we_d      = ~mem_read_in;
                        addr_d    = {addr_in[31:2], 2'b00};
                        wdata_d   = st_wdata;
                        wstrb_d   = st_wstrb;
                        cnt_d     = '0;
                        f3_d      = funct3_in;
                        off_d     = addr_in[1:0];
                    end else begin
                        aerr_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                stall_out = 1'b1;
                cnt_d     = cnt_q + 16'd1;
                if (bus_ready) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = ld_data;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    berr_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            // EX/MEM still holds the finished instruction here, so access is not looked at.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            stall_out = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    assign mem_rdata_out = rdata_q;
    assign access_err    = aerr_q;
    assign bus_err       = berr_q;
    assign bus_req       = req_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign bus_wstrb     = wstrb_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit for the 5-stage RISC-V pipeline. It sits between the EX/MEM and MEM/WB pipeline registers. It takes the registered access request (address, store data, size) and runs a req/ready transaction on the data-memory bus, converting between byte-addressed RV32 accesses and word-aligned bus beats. It aligns and extends load data for write-back, and drives the global stall that freezes every pipeline register until the access completes.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles without bus_ready before the access is aborted; range 1–65535.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- mem_read_in  in  1  load request from EX/MEM.
- mem_write_in  in  1  store request from EX/MEM.
- funct3_in  in  3  access size/sign from EX/MEM.
- addr_in  in  32  byte address (EX/MEM alu_result).
- store_data_in  in  32  store data (EX/MEM rdata2).
- mem_rdata_out  out  32  aligned, extended load data to MEM/WB.
- stall_out  out  1  holds PC and all pipeline registers.
- access_err  out  1  one-cycle pulse on a misaligned or illegal access.
- bus_err  out  1  one-cycle pulse on a timeout.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, {addr_in[31:2], 2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte enables; 4'b0000 on reads.
- bus_ready  in  1  completion; rdata is valid in the same cycle.
- bus_rdata  in  32  read word.

## Operation
- States: IDLE, WAIT, DONE.
- access = mem_read_in | mem_write_in. If both are high, the access is a read and the write is ignored.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Misalignment: halfword with addr[0]=1; word with addr[1:0]≠00.
- IDLE with a legal, aligned access:
  - stall_out=1 combinationally in that cycle.
  - Next edge: register bus_req=1 together with we/addr/wdata/wstrb, clear the timeout counter, go to WAIT.
- IDLE with an illegal or misaligned access:
  - Next edge: access_err=1 for one cycle.
  - No bus activity, stall_out stays 0, mem_rdata_out is unchanged.
- WAIT:
  - stall_out=1. Bus outputs are held stable; the counter increments each cycle.
  - bus_ready=1 → next edge: bus_req=0; for a load, register mem_rdata_out; go to DONE.
  - Counter reaches TIMEOUT_CYCLES with bus_ready=0 → next edge: bus_req=0, mem_rdata_out=0, bus_err=1 for one cycle, go to DONE.
- DONE:
  - stall_out=0, so the pipeline advances at the end of this cycle.
  - access is not evaluated, because EX/MEM still holds the completed instruction.
  - Always go to IDLE next edge.
- Store lanes:
  - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=d, wstrb=4'b1111.
- Load: shift bus_rdata right by 8·addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU) from bit 7/15. LW passes the word through.
- mem_rdata_out changes only on load completion, timeout, or reset. It holds its value otherwise.

## Timing
- Reset values: state IDLE; all-zero for mem_rdata_out, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, access_err, bus_err, and the counter.
- stall_out is 0 during reset.
- rst during WAIT: bus_req=0 on that edge and the transaction is abandoned. The bus side must tolerate the withdrawn request.
- Latency, with the access first seen in cycle 0 and bus_ready high in the first WAIT cycle:
  - cycle 1 is WAIT, cycle 2 is DONE;
  - stall is high in cycles 0–1 (2 cycles);
  - each additional WAIT cycle with bus_ready=0 adds one stall cycle.
- Timeout: bus_req stays high for exactly TIMEOUT_CYCLES cycles, then DONE.
- Back-to-back accesses: the access after DONE is detected in the following IDLE cycle. There is at most one bus transaction per instruction.
- bus_ready outside WAIT is ignored.

## Test plan
- Reset → all outputs zero, state IDLE; hold rst during WAIT → bus_req drops on the reset edge, stall_out=0.
- LW addr 0x100, bus_ready same cycle as req, rdata 0xDEADBEEF → bus_addr=0x100, stall for 2 cycles, mem_rdata_out=0xDEADBEEF in DONE.
- LB addr 0x103 with rdata 0x80FF1234 → 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102 → 0x000080FF.
- SB addr 0x201, data 0x000000AB → bus_we=1, wdata=0xABABABAB, wstrb=0010, bus_addr=0x200; SH addr 0x202, data 0x1234 → wstrb=1100.
- LW addr 0x102 → access_err pulse, bus_req never asserted, stall_out=0; funct3 011 load → same.
- TIMEOUT_CYCLES=4 with bus_ready held low → bus_req high for 4 cycles, then bus_err pulse, mem_rdata_out=0, stall released in DONE.
